// File: rtl/pc_sequencer_pkg.sv
// Purpose : shared encodings for the instruction sequencer (next-PC selects, FSM states, reset PC).
// Latency : n/a (declarations only).
// Backpr. : n/a.
package pc_sequencer_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    // Next-PC select codes driven by the decoder. 3'b111 is unassigned and
    // behaves like a sequential step.
    localparam logic [2:0] NPC_SEQ  = 3'b000;
    localparam logic [2:0] NPC_BEQ  = 3'b001;
    localparam logic [2:0] NPC_BNE  = 3'b010;
    localparam logic [2:0] NPC_J    = 3'b011;
    localparam logic [2:0] NPC_JAL  = 3'b100;
    localparam logic [2:0] NPC_JR   = 3'b101;
    localparam logic [2:0] NPC_STOP = 3'b110;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Purpose : instruction-memory fetch bus between the sequencer (master) and memory (slave).
// Latency : n/a (wires only); ports: imem_req/imem_addr from master, imem_ack/imem_rdata from slave.
// Backpr. : master holds imem_req and imem_addr until the slave returns imem_ack.
interface pc_sequencer_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/pc_sequencer_npc_calc.sv
// Purpose : combinational next-PC calculator; in: pc, instr, nPC_sel, zero, rs_val; out: next_pc, misaligned.
// Latency : 0 cycles (pure combinational).
// Backpr. : none; the caller decides when next_pc is consumed.
module npc_calc
    import pc_sequencer_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic [2:0]  nPC_sel,
    input  logic        zero,
    input  logic [31:0] rs_val,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    logic [31:0] seq_pc;
    logic [31:0] br_off;
    logic [31:0] br_pc;
    logic [31:0] jmp_pc;

    // Opcode bits are decoded elsewhere; only the immediate fields matter here.
    logic unused_opcode;
    assign unused_opcode = ^instr[31:26];

    assign seq_pc = pc + 32'd4;
    // Word offset: sign-extend the 16-bit immediate and scale to bytes.
    assign br_off = {{14{instr[15]}}, instr[15:0], 2'b00};
    assign br_pc  = seq_pc + br_off;
    // Pseudo-direct jump stays inside the 256 MB region of the delay-free pc+4.
    assign jmp_pc = {seq_pc[31:28], instr[25:0], 2'b00};

    always_comb begin
        next_pc    = seq_pc;
        misaligned = 1'b0;
        case (nPC_sel)
            NPC_SEQ:  next_pc = seq_pc;
            NPC_BEQ:  next_pc = zero ? br_pc : seq_pc;
            NPC_BNE:  next_pc = zero ? seq_pc : br_pc;
            NPC_J,
            NPC_JAL:  next_pc = jmp_pc;
            NPC_JR: begin
                next_pc    = rs_val;
                misaligned = (rs_val[1:0] != 2'b00);
            end
            NPC_STOP: next_pc = pc;
            default:  next_pc = seq_pc;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Purpose : fetch/execute sequencer: fetches at pc, holds instr for the datapath, retires and steers pc.
// Latency : 2 cycles per instruction minimum (1 FETCH with zero-wait ack, 1 EXEC); ports: clk, rst, imem bus, instr/exec_valid/ex_stall, nPC_sel/zero/rs_val, pc/pc_plus4, halted/fault/retire_cnt.
// Backpr. : FETCH waits for imem_ack; EXEC holds while ex_stall; HALT/FAULT idle until rst.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    pc_sequencer_if.master        imem,
    output logic [31:0]           instr,
    output logic                  exec_valid,
    input  logic                  ex_stall,
    input  logic [2:0]            nPC_sel,
    input  logic                  zero,
    input  logic [31:0]           rs_val,
    output logic [31:0]           pc,
    output logic [31:0]           pc_plus4,
    output logic                  halted,
    output logic                  fault,
    output logic [31:0]           retire_cnt
);

    state_t      state;
    logic        req_q;
    logic [31:0] next_pc;
    logic        misaligned;

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc;
    assign pc_plus4       = pc + 32'd4;

    npc_calc u_npc_calc (
        .pc         (pc),
        .instr      (instr),
        .nPC_sel    (nPC_sel),
        .zero       (zero),
        .rs_val     (rs_val),
        .next_pc    (next_pc),
        .misaligned (misaligned)
    );

    // Outputs are registered alongside the state so they always reflect it:
    // req_q==(state==FETCH), exec_valid==(state==EXEC), halted/fault likewise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            instr      <= '0;
            retire_cnt <= '0;
            req_q      <= 1'b1;
            exec_valid <= 1'b0;
            halted     <= 1'b0;
            fault      <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem.imem_ack) begin
                        instr      <= imem.imem_rdata;
                        state      <= EXEC;
                        req_q      <= 1'b0;
                        exec_valid <= 1'b1;
                    end
                end
                EXEC: begin
                    // Decoder inputs are only looked at on the retiring cycle.
                    if (!ex_stall) begin
                        exec_valid <= 1'b0;
                        if (misaligned) begin
                            // Bad jr target: freeze without retiring.
                            state <= FAULT;
                            fault <= 1'b1;
                        end else if (nPC_sel == NPC_STOP) begin
                            state      <= HALT;
                            halted     <= 1'b1;
                            retire_cnt <= retire_cnt + 32'd1;
                        end else begin
                            pc         <= next_pc;
                            retire_cnt <= retire_cnt + 32'd1;
                            state      <= FETCH;
                            req_q      <= 1'b1;
                        end
                    end
                end
                HALT, FAULT: begin
                    // Terminal until reset.
                end
                default: begin
                    state <= FAULT;
                end
            endcase
        end
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, the byte address of the first fetch after reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port imem_req  output  1  instruction fetch request.
REQ-005 SHALL have port imem_addr  output  32  fetch byte address, equal to pc.
REQ-006 SHALL have port imem_ack  input  1  fetch complete, imem_rdata valid this cycle.
REQ-007 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-008 SHALL have port instr  output  32  latched instruction under execution.
REQ-009 SHALL have port exec_valid  output  1  instr is being executed this cycle.
REQ-010 SHALL have port ex_stall  input  1  datapath holds the EXEC state.
REQ-011 SHALL have port nPC_sel  input  3  next-PC select from the decoder (000 seq, 001 beq, 010 bne, 011 j, 100 jal, 101 jr, 110 stop).
REQ-012 SHALL have port zero  input  1  ALU zero flag for the branch decision.
REQ-013 SHALL have port rs_val  input  32  register rs value for jr.
REQ-014 SHALL have port pc  output  32  address of the current instruction.
REQ-015 SHALL have port pc_plus4  output  32  pc+4, the link value for jal.
REQ-016 SHALL have port halted  output  1  stop retired, sequencer idle.
REQ-017 SHALL have port fault  output  1  misaligned jr target detected, sequencer idle.
REQ-018 SHALL have port retire_cnt  output  32  number of retired instructions.

Function
REQ-019 SHALL implement the states FETCH, EXEC, HALT and FAULT.
REQ-020 In FETCH, SHALL assert imem_req; on imem_ack, SHALL latch imem_rdata into instr and enter EXEC on the next cycle.
REQ-021 In EXEC, SHALL assert exec_valid; while ex_stall=1, SHALL hold the state, pc and instr.
REQ-022 In EXEC with ex_stall=0, SHALL retire the instruction: update pc, increment retire_cnt by 1 (wrapping at 2^32) and return to FETCH.
REQ-023 Minimum instruction latency SHALL be 2 cycles with a zero-wait memory: 1 in FETCH and 1 in EXEC.
REQ-024 Next PC SHALL be pc+4 when nPC_sel is 000, 111, beq with zero=0, or bne with zero=1.
REQ-025 A branch target SHALL be pc+4+(sign-extended instr[15:0] shifted left by 2), computed modulo 2^32.
REQ-026 The j and jal target SHALL be {pc_plus4[31:28], instr[25:0], 2'b00}.
REQ-027 The jr target SHALL be rs_val.
REQ-028 If rs_val[1:0] is not 0 on jr, SHALL enter FAULT, leave pc unchanged and not increment retire_cnt.
REQ-029 On stop (110), SHALL increment retire_cnt, leave pc unchanged and enter HALT.
REQ-030 HALT and FAULT SHALL be terminal until rst, with imem_req=0 and exec_valid=0.
REQ-031 halted SHALL equal (state==HALT) and fault SHALL equal (state==FAULT).
REQ-032 imem_ack SHALL be ignored whenever imem_req=0.
REQ-033 nPC_sel, zero and rs_val SHALL be sampled only in EXEC with ex_stall=0.
REQ-034 No delay slot: the instruction at pc+4 SHALL NOT execute after a taken branch or jump.

Reset
REQ-035 rst=1 SHALL immediately force state=FETCH, pc=RESET_PC, instr=0, retire_cnt=0, exec_valid=0, halted=0 and fault=0.
REQ-036 imem_req SHALL be 1 during and after reset, because FETCH is the reset state.
REQ-037 rst asserted mid-fetch or mid-EXEC SHALL discard the pending access; an imem_ack in the same cycle as rst SHALL be ignored.

Structure
REQ-038 A shared package SHALL hold the nPC_sel encodings, the state enum and the RESET_PC default.
REQ-039 Next-PC arithmetic SHALL live in a combinational sub-module npc_calc (inputs pc, instr, nPC_sel, zero, rs_val; outputs next pc and a misaligned flag).

Verification
REQ-040 Scenario: reset, then imem_ack on the first cycle with instr 32'h0000_0000 and nPC_sel=000 -> imem_addr 0x3000 then 0x3004, retire_cnt=1.
REQ-041 Scenario: pc 0x3010, beq with imm 16'hFFFF and zero=1 -> next pc 0x3010; same with zero=0 -> 0x3014.
REQ-042 Scenario: jal with instr[25:0]=26'h0000C10 at pc 0x3020 -> pc_plus4 0x3024 during EXEC, next pc 0x3040.
REQ-043 Scenario: jr with rs_val 0x3002 -> fault=1, pc unchanged, imem_req stays 0 until rst.
REQ-044 Scenario: 3 cycles of ex_stall then stop -> exec_valid held for 4 cycles, halted=1, retire_cnt incremented by 1, pc unchanged.
REQ-045 Scenario: rst asserted in the same cycle as imem_ack during a fetch at pc 0x3008 -> pc=0x3000, instr=0, FETCH next.
